ascon_perm_scheduler: RTL and testbench

//   Sequences and shares one combinational 2-round-per-cycle Ascon permutation core (p^12/p^8/p^6)

---
 rtl/ascon_perm_scheduler.sv | 117 +++++++++++
 tb/tb_ascon_perm_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_scheduler.sv
// rtl/ascon_perm_scheduler.sv - shares one 2-round/cycle Ascon permutation core between two requesters
// Optional per-requester completion counters: define ASCON_SCHED_STATS_EN.
module ascon_perm_scheduler #(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req_rounds0,
    input  logic [1:0]   req_rounds1,
    input  logic [319:0] req_state0,
    input  logic [319:0] req_state1,
    output logic [319:0] core_in,
    output logic [7:0]   core_aa,
    input  logic [319:0] core_out,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [319:0] resp_state
`ifdef ASCON_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] perm_cnt0,
    output logic [CNT_W-1:0] perm_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fsm_t;

    fsm_t           fsm;
    logic [319:0]   state_q;
    logic [2:0]     it_left;
    logic           rr_ptr;
    logic           any_valid;
    logic           grant_id;
    logic [1:0]     code_sel;

    always_comb begin
        any_valid = |req_valid;
        if (RR_EN != 0 && rr_ptr)
            grant_id = req_valid[1] ? 1'b1 : 1'b0;
        else
            grant_id = req_valid[0] ? 1'b0 : 1'b1;
        req_ready = 2'b00;
        if (fsm == IDLE && any_valid)
            req_ready = grant_id ? 2'b10 : 2'b01;
        code_sel = grant_id ? req_rounds1 : req_rounds0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm        <= IDLE;
            state_q    <= '0;
            core_aa    <= 8'hFF;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            it_left    <= 3'd0;
            rr_ptr     <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (any_valid) begin
                        state_q <= grant_id ? req_state1 : req_state0;
                        resp_id <= grant_id;
                        rr_ptr  <= ~grant_id;
                        // first constant byte is that of the first double-round of p^(2*N_it)
                        case (code_sel)
                            2'b01: begin it_left <= 3'd4; core_aa <= 8'hC3; end
                            2'b10: begin it_left <= 3'd3; core_aa <= 8'hA5; end
                            default: begin it_left <= 3'd6; core_aa <= 8'hFF; end
                        endcase
                        fsm <= RUN;
                    end
                end
                RUN: begin
                    state_q <= core_out;
                    core_aa <= core_aa - 8'h1E;
                    it_left <= it_left - 3'd1;
                    if (it_left == 3'd1) begin
                        fsm        <= HOLD;
                        resp_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        fsm        <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign core_in    = state_q;
    assign resp_state = state_q;

`ifdef ASCON_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perm_cnt0 <= '0;
            perm_cnt1 <= '0;
        end else if (resp_valid && resp_ready) begin
            if (!resp_id && perm_cnt0 != '1)
                perm_cnt0 <= perm_cnt0 + 1'b1;
            if (resp_id && perm_cnt1 != '1)
                perm_cnt1 <= perm_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// tb/tb_ascon_perm_scheduler.sv - self-checking bench for ascon_perm_scheduler
module tb_ascon_perm_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_rounds0, req_rounds1;
    logic [319:0] req_state0, req_state1;
    logic         resp_ready;

    logic [1:0]   req_ready_rr, req_ready_fp;
    logic [319:0] core_in_rr, core_in_fp, core_out_rr, core_out_fp;
    logic [319:0] resp_state_rr, resp_state_fp;
    logic [7:0]   core_aa_rr, core_aa_fp;
    logic         resp_valid_rr, resp_valid_fp, resp_id_rr, resp_id_fp;
`ifdef ASCON_SCHED_STATS_EN
    logic [3:0]   perm_cnt0_rr, perm_cnt1_rr, perm_cnt0_fp, perm_cnt1_fp;
`endif

    int errors = 0;
    int checks = 0;
    int rr_model = 0;

    ascon_perm_scheduler #(.RR_EN(1), .CNT_W(4)) u_rr (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_rr),
        .req_rounds0(req_rounds0), .req_rounds1(req_rounds1),
        .req_state0(req_state0), .req_state1(req_state1),
        .core_in(core_in_rr), .core_aa(core_aa_rr), .core_out(core_out_rr),
        .resp_valid(resp_valid_rr), .resp_ready(resp_ready), .resp_id(resp_id_rr),
        .resp_state(resp_state_rr)
`ifdef ASCON_SCHED_STATS_EN
        , .perm_cnt0(perm_cnt0_rr), .perm_cnt1(perm_cnt1_rr)
`endif
    );

    ascon_perm_scheduler #(.RR_EN(0), .CNT_W(4)) u_fp (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_fp),
        .req_rounds0(req_rounds0), .req_rounds1(req_rounds1),
        .req_state0(req_state0), .req_state1(req_state1),
        .core_in(core_in_fp), .core_aa(core_aa_fp), .core_out(core_out_fp),
        .resp_valid(resp_valid_fp), .resp_ready(resp_ready), .resp_id(resp_id_fp),
        .resp_state(resp_state_fp)
`ifdef ASCON_SCHED_STATS_EN
        , .perm_cnt0(perm_cnt0_fp), .perm_cnt1(perm_cnt1_fp)
`endif
    );

    function automatic logic [63:0] ror(input logic [63:0] v, input int r);
        return (v >> r) | (v << (64 - r));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, c};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Ascon round constant i of the 12-round schedule: f0, e1, d2, ... 4b
    function automatic logic [7:0] rc(input int i);
        return 8'(((15 - i) << 4) | i);
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
        logic [319:0] r;
        r = s;
        for (int i = 12 - nr; i < 12; i++) r = ascon_round(r, rc(i));
        return r;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom())};
        return r;
    endfunction

    always_comb core_out_rr = ascon_round(ascon_round(core_in_rr, core_aa_rr - 8'h0F), core_aa_rr - 8'h1E);
    always_comb core_out_fp = ascon_round(ascon_round(core_in_fp, core_aa_fp - 8'h0F), core_aa_fp - 8'h1E);

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge+ with the DUTs idle (or finishing a handoff); leaves time at a negedge+.
    task automatic do_perm(input logic [1:0] mask, input logic [1:0] code, input int hold,
                           input bit chain, input logic [319:0] s0, input logic [319:0] s1,
                           input int exp_lat, input logic [7:0] exp_aa0);
        int rounds, n, g, gf, lat;
        logic [319:0] exp_rr, exp_fp;
        rounds = (code == 2'b01) ? 8 : (code == 2'b10) ? 6 : 12;
        n  = rounds / 2;
        g  = mask[rr_model] ? rr_model : 1 - rr_model;
        gf = mask[0] ? 0 : 1;
        rr_model = 1 - g;
        exp_rr = ref_perm((g == 1) ? s1 : s0, rounds);
        exp_fp = ref_perm((gf == 1) ? s1 : s0, rounds);
        req_state0 = s0; req_state1 = s1;
        req_rounds0 = code; req_rounds1 = code;
        req_valid = mask; resp_ready = 1'b0;
        #1;
        check("grant_rr", req_ready_rr, 2'b01 << g);
        check("grant_fp", req_ready_fp, 2'b01 << gf);
        lat = -1;
        for (int k = 1; k <= n + 3 && lat < 0; k++) begin
            @(negedge clk);
            req_valid = 2'($urandom());
            #1;
            if (resp_valid_rr) lat = k;
            else begin
                check("run_ready", req_ready_rr, 0);
                if (k <= n) check("aa_seq", core_aa_rr, rc(12 - rounds + 2 * (k - 1)) + 8'h0F);
                if (k == 1) check("aa_first", core_aa_rr, exp_aa0);
            end
        end
        check("latency", lat, exp_lat);
        check("resp_id_rr", resp_id_rr, g);
        check("resp_state_rr", resp_state_rr, exp_rr);
        check("resp_id_fp", resp_id_fp, gf);
        check("resp_state_fp", resp_state_fp, exp_fp);
        req_valid = mask;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check("hold_valid", resp_valid_rr, 1);
            check("hold_state", resp_state_rr, exp_rr);
            check("hold_id", resp_id_rr, g);
            check("hold_ready", req_ready_rr, 0);
        end
        resp_ready = 1'b1;
        #1;
        check("handoff_ready", req_ready_rr, 0);
        @(negedge clk);
        resp_ready = 1'b0;
        if (!chain) req_valid = 2'b00;
        #1;
        check("idle_valid", resp_valid_rr, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", req_ready_rr, 0);
        check("rst_core_in", core_in_rr, 0);
        check("rst_aa", core_aa_rr, 8'hFF);
        check("rst_valid", resp_valid_rr, 0);
        check("rst_id", resp_id_rr, 0);
    endtask

    typedef struct {
        logic [1:0] mask;
        logic [1:0] code;
        int         hold;
        bit         chain;
        int         exp_lat;
        logic [7:0] exp_aa0;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] m, c;
        vecs[0] = '{2'b01, 2'b00, 0,  1'b0, 7, 8'hFF};
        vecs[1] = '{2'b10, 2'b01, 0,  1'b0, 5, 8'hC3};
        vecs[2] = '{2'b10, 2'b10, 1,  1'b0, 4, 8'hA5};
        vecs[3] = '{2'b10, 2'b11, 0,  1'b0, 7, 8'hFF};
        vecs[4] = '{2'b11, 2'b00, 0,  1'b0, 7, 8'hFF};
        vecs[5] = '{2'b11, 2'b01, 0,  1'b0, 5, 8'hC3};
        vecs[6] = '{2'b11, 2'b10, 2,  1'b0, 4, 8'hA5};
        vecs[7] = '{2'b01, 2'b10, 10, 1'b1, 4, 8'hA5};
        vecs[8] = '{2'b01, 2'b01, 0,  1'b0, 5, 8'hC3};

        reset = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
        req_rounds0 = 2'b00; req_rounds1 = 2'b00;
        req_state0 = '0; req_state1 = '0;
        @(negedge clk); @(negedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clk);
        #1;

        // IV with K = N = 0 first, then random states
        for (int i = 0; i < 9; i++)
            do_perm(vecs[i].mask, vecs[i].code, vecs[i].hold, vecs[i].chain,
                    (i == 0) ? {64'h80800c0800000000, 256'd0} : rand320(), rand320(),
                    vecs[i].exp_lat, vecs[i].exp_aa0);

        for (int i = 0; i < 20; i++) begin
            m = 2'($urandom_range(1, 3));
            c = 2'($urandom_range(0, 3));
            do_perm(m, c, int'($urandom_range(0, 3)), 1'($urandom()), rand320(), rand320(),
                    (c == 2'b01) ? 5 : (c == 2'b10) ? 4 : 7,
                    (c == 2'b01) ? 8'hC3 : (c == 2'b10) ? 8'hA5 : 8'hFF);
        end
        req_valid = 2'b00;

        // abort in the third RUN cycle
        @(negedge clk);
        req_state0 = rand320(); req_rounds0 = 2'b00; req_valid = 2'b01;
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        rr_model = 0;
        #1;
        check_reset_outputs();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("abort_no_resp", resp_valid_rr, 0);
        end

        // round-robin from reset: 0, 1, 0
        for (int i = 0; i < 3; i++)
            do_perm(2'b11, 2'b10, 0, 1'b0, rand320(), rand320(), 4, 8'hA5);

`ifdef ASCON_SCHED_STATS_EN
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; rr_model = 0;
        #1;
        check("cnt0_reset", perm_cnt0_rr, 0);
        check("cnt1_reset", perm_cnt1_rr, 0);
        for (int i = 0; i < 17; i++)
            do_perm(2'b01, 2'b10, 0, 1'b0, rand320(), rand320(), 4, 8'hA5);
        check("cnt0_sat", perm_cnt0_rr, 4'd15);
        check("cnt1_zero", perm_cnt1_rr, 4'd0);
        check("cnt0_sat_fp", perm_cnt0_fp, 4'd15);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
